// File: rtl/crc32_pkg.sv
// Shared constants, state encoding and bit-reversal helpers for the streaming CRC-32 engine.
package crc32_pkg;

    localparam int unsigned CRC_W  = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [CRC_W-1:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [CRC_W-1:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [CRC_W-1:0] CRC32_XOROUT  = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } crc_state_e;

    function automatic logic [BYTE_W-1:0] bitrev8(input logic [BYTE_W-1:0] v);
        logic [BYTE_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            r[i] = v[int'(BYTE_W) - 1 - i];
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] bitrev32(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CRC_W); i++) begin
            r[i] = v[int'(CRC_W) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// One byte of CRC-32 in the non-reflected register domain; the byte is bit-reversed on entry.
module crc32_byte_step
    import crc32_pkg::*;
(
    input  logic [CRC_W-1:0]  crc_cur,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [CRC_W-1:0]  crc_next
);

    logic [CRC_W-1:0] crc;

    // MSB-first shift, one polynomial reduction per input bit
    always_comb begin
        crc = crc_cur ^ {bitrev8(byte_data), (CRC_W - BYTE_W)'(0)};
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (crc[CRC_W-1]) begin
                crc = (crc << 1) ^ CRC32_POLY;
            end else begin
                crc = crc << 1;
            end
        end
        crc_next = crc;
    end

endmodule

// File: rtl/crc32_stream.sv
// Ethernet CRC-32 over a multi-lane valid/ready byte stream with framing,
// FCS check, saturating byte count and a held result handshake.
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int unsigned DW_BYTES = 4,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*DW_BYTES-1:0]    in_data,
    input  logic [DW_BYTES-1:0]      in_keep,
    input  logic                     in_last,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CRC_W-1:0]         res_crc,
    output logic                     res_ok,
    output logic [LEN_W-1:0]         res_len
);

    localparam int unsigned CNT_W = $clog2(DW_BYTES + 1);
    localparam int unsigned SUM_W = LEN_W + 1;

    crc_state_e         state, state_n;
    logic [CRC_W-1:0]   crc_reg, crc_n;
    logic [LEN_W-1:0]   len_reg, len_n;
    logic               res_valid_n;
    logic [CRC_W-1:0]   res_crc_n;
    logic               res_ok_n;
    logic [LEN_W-1:0]   res_len_n;

    logic               accept;
    logic [CNT_W-1:0]   keep_cnt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CRC_W-1:0]   crc_tap;
    logic [SUM_W-1:0]   len_sum;
    logic [LEN_W-1:0]   len_sat;
    logic [CRC_W-1:0]   taps [DW_BYTES+1];

    assign in_ready = !abort && (!res_valid || res_ready);
    assign accept   = in_valid && in_ready;

    // Lane chain: taps[i] is the register after the first i lanes of the beat
    assign taps[0] = crc_reg;
    for (genvar g = 0; g < int'(DW_BYTES); g++) begin : g_lane
        crc32_byte_step u_step (
            .crc_cur   (taps[g]),
            .byte_data (in_data[8*g +: 8]),
            .crc_next  (taps[g+1])
        );
    end

    // Keep is contiguous from lane 0, so its popcount selects the chain tap
    always_comb begin
        keep_cnt = '0;
        for (int unsigned i = 0; i < DW_BYTES; i++) begin
            keep_cnt = keep_cnt + CNT_W'(in_keep[i]);
        end
        beat_cnt = in_last ? keep_cnt : CNT_W'(DW_BYTES);
    end

    always_comb begin
        crc_tap = taps[0];
        for (int unsigned i = 0; i <= DW_BYTES; i++) begin
            if (beat_cnt == CNT_W'(i)) begin
                crc_tap = taps[i];
            end
        end
    end

    // Length counter saturates at all-ones instead of wrapping
    always_comb begin
        len_sum = {1'b0, len_reg} + SUM_W'(beat_cnt);
        len_sat = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    end

    always_comb begin
        state_n     = state;
        crc_n       = crc_reg;
        len_n       = len_reg;
        res_valid_n = res_valid;
        res_crc_n   = res_crc;
        res_ok_n    = res_ok;
        res_len_n   = res_len;

        if (abort) begin
            state_n     = IDLE;
            crc_n       = CRC32_INIT;
            len_n       = '0;
            res_valid_n = 1'b0;
        end else begin
            if (state == DONE && res_ready) begin
                state_n     = IDLE;
                res_valid_n = 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    state_n     = DONE;
                    res_valid_n = 1'b1;
                    res_crc_n   = bitrev32(crc_tap) ^ CRC32_XOROUT;
                    res_ok_n    = (crc_tap == CRC32_RESIDUE);
                    res_len_n   = len_sat;
                    crc_n       = CRC32_INIT;
                    len_n       = '0;
                end else begin
                    state_n = BUSY;
                    crc_n   = crc_tap;
                    len_n   = len_sat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_reg   <= CRC32_INIT;
            len_reg   <= '0;
            res_valid <= 1'b0;
            res_crc   <= '0;
            res_ok    <= 1'b0;
            res_len   <= '0;
        end else begin
            state     <= state_n;
            crc_reg   <= crc_n;
            len_reg   <= len_n;
            res_valid <= res_valid_n;
            res_crc   <= res_crc_n;
            res_ok    <= res_ok_n;
            res_len   <= res_len_n;
        end
    end

endmodule

// File: tb/tb_crc32_stream.sv
// Self-checking bench for crc32_stream against a reflected software CRC-32 model.
module tb_crc32_stream;

    parameter int unsigned DW = 4;
    parameter int unsigned LW = 16;

    typedef logic [7:0] byte_t;
    typedef struct {
        logic [8*DW-1:0] d;
        logic [DW-1:0]   k;
        logic            l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst, abort, in_valid, in_ready, in_last;
    logic              res_valid, res_ready, res_ok;
    logic [8*DW-1:0]   in_data;
    logic [DW-1:0]     in_keep;
    logic [31:0]       res_crc;
    logic [LW-1:0]     res_len;

    int checks = 0;
    int errors = 0;
    beat_t bq[$];

    always #5 clk = ~clk;

    crc32_stream #(.DW_BYTES(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_crc   (res_crc),
        .res_ok    (res_ok),
        .res_len   (res_len)
    );

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: textbook reflected CRC-32, register returned before final complement
    function automatic logic [31:0] ref_reg(input byte_t q[$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (q[i]) begin
            r = r ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_crc(input byte_t q[$]);
        return ~ref_reg(q);
    endfunction

    function automatic logic ref_ok(input byte_t q[$]);
        return ref_reg(q) == 32'hDEBB20E3;
    endfunction

    function automatic logic [LW-1:0] ref_len(input int n);
        longint m;
        m = (longint'(1) << LW) - 1;
        return (longint'(n) > m) ? LW'(m) : LW'(n);
    endfunction

    task automatic pack_frame(input byte_t q[$]);
        beat_t b;
        int n, nb, idx;
        bq.delete();
        n  = q.size();
        nb = (n + int'(DW) - 1) / int'(DW);
        if (nb == 0) nb = 1;
        for (int i = 0; i < nb; i++) begin
            b.l = (i == nb - 1);
            b.k = b.l ? '0 : DW'($urandom);
            for (int l = 0; l < int'(DW); l++) begin
                idx = i * int'(DW) + l;
                b.d[8*l +: 8] = 8'($urandom_range(0, 255));
                if (idx < n) begin
                    b.d[8*l +: 8] = q[idx];
                    if (b.l) b.k[l] = 1'b1;
                end
            end
            bq.push_back(b);
        end
    endtask

    task automatic drive_beat(input beat_t b, output bit acc);
        in_valid = 1'b1;
        in_data  = b.d;
        in_keep  = b.k;
        in_last  = b.l;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%b expected 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic send_frame(input byte_t q[$], input bit gaps);
        bit acc;
        pack_frame(q);
        foreach (bq[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            drive_beat(bq[i], acc);
            if (!acc) return;
        end
    endtask

    task automatic take_result(input int delay, output logic [31:0] c, output logic o,
                               output logic [LW-1:0] n);
        bit got;
        res_ready = 1'b0;
        c = 'x; o = 1'bx; n = 'x;
        repeat (delay) begin
            if (res_valid === 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_in_ready got=%b expected=0", in_ready);
                end
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            if (res_valid === 1'b1) begin
                c = res_crc; o = res_ok; n = res_len; got = 1'b1;
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL result_timeout res_valid=%b expected 1 within 500 cycles", res_valid);
        end
    endtask

    function automatic void seq9(output byte_t q[$]);
        q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks += 5;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b expected=0", res_valid); end
        if (res_crc !== 32'h0)  begin errors++; $display("FAIL reset_crc got=%h expected=0", res_crc); end
        if (res_ok !== 1'b0)    begin errors++; $display("FAIL reset_ok got=%b expected=0", res_ok); end
        if (res_len !== '0)     begin errors++; $display("FAIL reset_len got=%0d expected=0", res_len); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got=%b expected=1", in_ready); end
    endtask

    task automatic test_known();
        byte_t q[$];
        logic [31:0] c; logic o; logic [LW-1:0] n;
        seq9(q);
        send_frame(q, 1'b0);
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL known_latency res_valid=%b expected=1", res_valid); end
        take_result(0, c, o, n);
        checks += 4;
        if (c !== 32'hCBF43926) begin errors++; $display("FAIL known_crc got=%h expected=cbf43926", c); end
        if (c !== ref_crc(q))   begin errors++; $display("FAIL known_model got=%h expected=%h", c, ref_crc(q)); end
        if (n !== ref_len(9))   begin errors++; $display("FAIL known_len got=%0d expected=%0d", n, ref_len(9)); end
        if (o !== 1'b0)         begin errors++; $display("FAIL known_ok got=%b expected=0", o); end
    endtask

    task automatic test_fcs();
        byte_t q[$];
        logic [31:0] c; logic o; logic [LW-1:0] n;
        seq9(q);
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        send_frame(q, 1'b1);
        take_result(1, c, o, n);
        checks += 2;
        if (o !== 1'b1)        begin errors++; $display("FAIL fcs_ok got=%b expected=1", o); end
        if (n !== ref_len(13)) begin errors++; $display("FAIL fcs_len got=%0d expected=%0d", n, ref_len(13)); end
        q[2] = q[2] ^ 8'h01;
        send_frame(q, 1'b1);
        take_result(2, c, o, n);
        checks += 2;
        if (o !== 1'b0)        begin errors++; $display("FAIL fcs_flip_ok got=%b expected=0", o); end
        if (c !== ref_crc(q))  begin errors++; $display("FAIL fcs_flip_crc got=%h expected=%h", c, ref_crc(q)); end
    endtask

    task automatic test_backpressure();
        byte_t q[$];
        bit acc;
        logic [31:0] c; logic o; logic [LW-1:0] n;
        seq9(q);
        send_frame(q, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks += 3;
            if (in_ready !== 1'b0)       begin errors++; $display("FAIL bp_ready cyc=%0d got=%b expected=0", i, in_ready); end
            if (res_crc !== 32'hCBF43926) begin errors++; $display("FAIL bp_crc cyc=%0d got=%h expected=cbf43926", i, res_crc); end
            if (res_len !== ref_len(9))  begin errors++; $display("FAIL bp_len cyc=%0d got=%0d expected=9", i, res_len); end
            @(posedge clk); #1;
        end
        q = {8'h00, 8'h00, 8'h00, 8'h00};
        pack_frame(q);
        res_ready = 1'b1;
        in_valid = 1'b1; in_data = bq[0].d; in_keep = bq[0].k; in_last = bq[0].l;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_same_cycle in_ready=%b expected=1", in_ready); end
        @(posedge clk); #1;
        res_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        for (int i = 1; i < bq.size(); i++) drive_beat(bq[i], acc);
        checks += 3;
        if (res_valid !== 1'b1)      begin errors++; $display("FAIL bp_new_valid got=%b expected=1", res_valid); end
        if (res_crc !== 32'h2144DF1C) begin errors++; $display("FAIL bp_new_crc got=%h expected=2144df1c", res_crc); end
        if (res_len !== ref_len(4))  begin errors++; $display("FAIL bp_new_len got=%0d expected=4", res_len); end
        take_result(0, c, o, n);
    endtask

    task automatic test_abort();
        byte_t q[$];
        bit acc;
        logic [31:0] c; logic o; logic [LW-1:0] n;
        for (int i = 0; i < 3 * int'(DW); i++) q.push_back(8'($urandom));
        pack_frame(q);
        drive_beat(bq[0], acc);
        drive_beat(bq[1], acc);
        abort = 1'b1;
        in_valid = 1'b1; in_data = bq[2].d; in_keep = bq[2].k; in_last = bq[2].l;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b expected=0", in_ready); end
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_stale cyc=%0d got=%b expected=0", i, res_valid); end
            @(posedge clk); #1;
        end
        seq9(q);
        send_frame(q, 1'b1);
        take_result(1, c, o, n);
        checks += 2;
        if (c !== 32'hCBF43926) begin errors++; $display("FAIL abort_crc got=%h expected=cbf43926", c); end
        if (n !== ref_len(9))   begin errors++; $display("FAIL abort_len got=%0d expected=9", n); end
        send_frame(q, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_result got=%b expected=0", res_valid); end
    endtask

    task automatic test_rst();
        byte_t q[$];
        bit acc;
        logic [31:0] c; logic o; logic [LW-1:0] n;
        for (int i = 0; i < 3 * int'(DW); i++) q.push_back(8'($urandom));
        pack_frame(q);
        drive_beat(bq[0], acc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b expected=0", res_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_ready got=%b expected=1", in_ready); end
        seq9(q);
        send_frame(q, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 4;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got=%b expected=0", res_valid); end
        if (res_crc !== 32'h0)  begin errors++; $display("FAIL rst_res_crc got=%h expected=0", res_crc); end
        if (res_ok !== 1'b0)    begin errors++; $display("FAIL rst_res_ok got=%b expected=0", res_ok); end
        if (res_len !== '0)     begin errors++; $display("FAIL rst_res_len got=%0d expected=0", res_len); end
        send_frame(q, 1'b1);
        take_result(0, c, o, n);
        checks += 2;
        if (c !== 32'hCBF43926) begin errors++; $display("FAIL rst_after_crc got=%h expected=cbf43926", c); end
        if (n !== ref_len(9))   begin errors++; $display("FAIL rst_after_len got=%0d expected=9", n); end
    endtask

    task automatic test_random();
        byte_t q[$];
        int len;
        logic [31:0] c, fcs; logic o; logic [LW-1:0] n;
        for (int f = 0; f < 24; f++) begin
            q.delete();
            len = (f == 0) ? 64 : int'($urandom_range(0, 80));
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            if (len > 0 && $urandom_range(0, 2) == 0) begin
                fcs = ref_crc(q);
                for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
            end
            send_frame(q, 1'b1);
            take_result(int'($urandom_range(0, 4)), c, o, n);
            checks += 3;
            if (c !== ref_crc(q))       begin errors++; $display("FAIL rand_crc f=%0d got=%h expected=%h", f, c, ref_crc(q)); end
            if (o !== ref_ok(q))        begin errors++; $display("FAIL rand_ok f=%0d got=%b expected=%b", f, o, ref_ok(q)); end
            if (n !== ref_len(q.size())) begin errors++; $display("FAIL rand_len f=%0d got=%0d expected=%0d", f, n, ref_len(q.size())); end
        end
    endtask

    task automatic test_saturation();
        byte_t q[$];
        int len;
        logic [31:0] c; logic o; logic [LW-1:0] n;
        len = (1 << LW) + 5;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        send_frame(q, 1'b0);
        take_result(0, c, o, n);
        checks += 2;
        if (n !== {LW{1'b1}})  begin errors++; $display("FAIL sat_len got=%0d expected=%0d", n, ref_len(len)); end
        if (c !== ref_crc(q))  begin errors++; $display("FAIL sat_crc got=%h expected=%h", c, ref_crc(q)); end
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        in_keep = '0; in_last = 1'b0; res_ready = 1'b0;
        test_reset();
        test_known();
        test_fcs();
        test_backpressure();
        test_abort();
        test_rst();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
